vscale_hasti_sram_arbiter: RTL and testbench
============================================

// Module: vscale_hasti_sram_arbiter
// PURPOSE
//  Two-master, one-slave HASTI (AHB-lite subset) arbiter sharing a single-port SRAM between the
//  instruction (m0) and data (m1) masters. Sits between the core's HASTI master ports and one
//  SRAM slave port. Uncontended transfers pass through with zero added latency. The losing
//  master's address phase is buffered and its hready is held low until the transfer completes.
// PARAMETERS
//  FIXED_PRIO  0  0 = round-robin between m0/m1; 1 = m0 always wins a contended slot
// PORTS
//  hclk            in   1                   clock; all state updates on posedge
//  hresetn         in   1                   reset, synchronous, active-low
//  mN_haddr        in   HASTI_ADDR_WIDTH    master N address (N = 0,1)
//  mN_hwrite       in   1                   master N write
//  mN_hsize        in   HASTI_SIZE_WIDTH    master N size
//  mN_htrans       in   HASTI_TRANS_WIDTH   master N trans; only IDLE/NONSEQ are used
//  mN_hwdata       in   HASTI_BUS_WIDTH     master N write data, valid in its data phase
//  mN_hrdata       out  HASTI_BUS_WIDTH     read data; equals s_hrdata for both masters
//  mN_hready       out  1                   master N ready
//  mN_hresp        out  1                   master N response
//  s_haddr/s_hwrite/s_hsize/s_htrans  out   to SRAM slave; address phase of granted transfer
//  s_hwdata        out  HASTI_BUS_WIDTH     write data from the data-phase owner
//  s_hrdata        in   HASTI_BUS_WIDTH     slave read data
//  s_hready        in   1                   slave ready
//  s_hresp         in   1                   slave response
// BEHAVIOUR
//  Reset (hresetn=0 at posedge): pend0/pend1 cleared, dp_owner=NONE, last_grant=m1 (m0 wins first).
//   While in reset: s_htrans=IDLE, mN_hready=1, mN_hresp=OKAY. In-flight and buffered transfers
//   are dropped.
//  Request: master N requests when (mN_htrans==NONSEQ && mN_hready==1) or pendN==1.
//   Pending buffer pendN holds {addr, write, size}.
//  Grant (combinational, evaluated each cycle when s_hready==1):
//   - exactly one requester -> that requester is granted;
//   - both -> FIXED_PRIO=1: m0; else the master != last_grant.
//   - Grant drives s_haddr/hwrite/hsize from pendN if set, else from live mN_*; s_htrans=NONSEQ.
//   - No grant, or s_hready==0 -> s_htrans=IDLE. Slave address fields hold their last values.
//  Posedge with s_hready==1: dp_owner <= granted master (or NONE); last_grant updated on grant.
//   - pendN cleared if N is granted.
//   - pendN set if N issued a live NONSEQ (with mN_hready=1) and was not granted.
//  Posedge with s_hready==0: dp_owner, pendN and last_grant hold. A live NONSEQ from a master
//   with mN_hready=1 that is not accepted is captured into pendN.
//  mN_hready = 0 if pendN==1; else s_hready if dp_owner==N; else 1.
//  mN_hresp = s_hresp if dp_owner==N, else OKAY.
//   - s_hwdata = mN_hwdata of dp_owner.
//   - dp_owner==NONE -> s_hwdata = 0.
//  Per-master state:
//   - IDLE -> DATA when granted;
//   - IDLE -> WAIT when its request is not granted.
//   - WAIT -> DATA when granted.
//   - DATA -> IDLE/DATA/WAIT, chosen by the next request in the cycle its data phase completes.
//  Latency: uncontended = slave latency; loser adds exactly one slave data phase per lost slot.
//  Fairness: round-robin guarantees a waiting master is granted within 1 slot.
//   A master never holds two outstanding transfers.
//  Back-to-back: a master may issue a new NONSEQ in the cycle its data phase completes
//   (mN_hready=1). That request arbitrates normally.
//  s_hresp ERROR is forwarded to the owner only. The arbiter takes no other action.
// TESTING
//  1 Reset, m0 NONSEQ read 0x100 alone, SRAM ready -> s_haddr=0x100 same cycle;
//    m0_hready=1 throughout; m1_hready=1.
//  2 Both NONSEQ same cycle (m0 rd 0x10, m1 wr 0x20 data 0xDEADBEEF) -> m0 granted first.
//    Next cycle: s_haddr=0x20 from pend1, m1_hready=0. Cycle after: s_hwdata=0xDEADBEEF,
//    m1_hready=1.
//  3 Both request continuously for 8 slots, FIXED_PRIO=0 -> grants alternate m0,m1,m0,...
//    FIXED_PRIO=1 with m0 continuous -> m1 never granted while m0 requests.
//  4 s_hready=0 for 3 cycles during m0 data phase while m1 issues NONSEQ -> pend1 captured;
//    m0_hready=0 for 3 cycles. m1 granted on the first s_hready=1 cycle.
//  5 hresetn=0 while pend1 set and m0 in data phase -> next cycle s_htrans=IDLE,
//    both hready=1, no stale transfer issued after reset.
//  6 m1 write 0x40=0x11223344, then m0 read 0x40 -> m0_hrdata=0x11223344
//    (with dp_hasti_sram-style bypassing slave).

Source files
------------

// File: rtl/vscale_hasti_sram_arbiter.sv
// Two-master / one-slave HASTI arbiter sharing a single-port SRAM between
// the instruction (m0) and data (m1) masters. An uncontended address phase
// passes straight through. A losing master's address phase is parked in a
// pending buffer, and its hready stays low until that transfer is issued.
module vscale_hasti_sram_arbiter #(
  parameter int HASTI_ADDR_WIDTH  = 32,
  parameter int HASTI_BUS_WIDTH   = 32,
  parameter int HASTI_SIZE_WIDTH  = 3,
  parameter int HASTI_TRANS_WIDTH = 2,
  parameter int FIXED_PRIO        = 0
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic                         m0_hresp,
  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic                         m1_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic                         s_hresp
);

  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_IDLE   = '0;
  localparam logic [HASTI_TRANS_WIDTH-1:0] TRANS_NONSEQ = HASTI_TRANS_WIDTH'(2);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

  owner_e dp_owner, dp_owner_nxt;
  logic   last_grant;            // 0: m0 won the last slot, 1: m1 did
  logic   pend0, pend1;
  logic   live0, live1, req0, req1, gnt0, gnt1;

  // Parked address phases and the last issued slave address fields (data only, never reset)
  logic [HASTI_ADDR_WIDTH-1:0] pend0_addr, pend1_addr, hold_addr;
  logic                        pend0_write, pend1_write, hold_write;
  logic [HASTI_SIZE_WIDTH-1:0] pend0_size, pend1_size, hold_size;

  // Requests: a fresh NONSEQ is only seen while the master's hready is high
  always_comb begin
    live0 = (m0_htrans == TRANS_NONSEQ) && m0_hready;
    live1 = (m1_htrans == TRANS_NONSEQ) && m1_hready;
    req0  = live0 || pend0;
    req1  = live1 || pend1;
  end

  // Grant: only while the slave can accept an address phase and out of reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (hresetn && s_hready) begin
      if (req0 && req1) begin
        if ((FIXED_PRIO != 0) || last_grant) gnt0 = 1'b1;
        else                                 gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Slave address phase: parked request takes precedence over the live bus
  always_comb begin
    s_htrans = TRANS_IDLE;
    s_haddr  = hold_addr;
    s_hwrite = hold_write;
    s_hsize  = hold_size;
    if (gnt0) begin
      s_htrans = TRANS_NONSEQ;
      s_haddr  = pend0 ? pend0_addr  : m0_haddr;
      s_hwrite = pend0 ? pend0_write : m0_hwrite;
      s_hsize  = pend0 ? pend0_size  : m0_hsize;
    end else if (gnt1) begin
      s_htrans = TRANS_NONSEQ;
      s_haddr  = pend1 ? pend1_addr  : m1_haddr;
      s_hwrite = pend1 ? pend1_write : m1_hwrite;
      s_hsize  = pend1 ? pend1_size  : m1_hsize;
    end
  end

  // Next data-phase owner: moves only when the current data phase completes
  always_comb begin
    dp_owner_nxt = dp_owner;
    if (s_hready) begin
      if (gnt0)      dp_owner_nxt = OWN_M0;
      else if (gnt1) dp_owner_nxt = OWN_M1;
      else           dp_owner_nxt = OWN_NONE;
    end
  end

  // Data-phase owner register
  always_ff @(posedge hclk) begin
    if (!hresetn) dp_owner <= OWN_NONE;
    else          dp_owner <= dp_owner_nxt;
  end

  // Pending flags and round-robin pointer; grants are zero during a slave stall,
  // so both hold and only fresh NONSEQs are captured
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (gnt0)       pend0 <= 1'b0;
      else if (live0) pend0 <= 1'b1;
      if (gnt1)       pend1 <= 1'b0;
      else if (live1) pend1 <= 1'b1;
      if (gnt0)       last_grant <= 1'b0;
      else if (gnt1)  last_grant <= 1'b1;
    end
  end

  // Capture losing address phases and remember the last issued slave fields
  always_ff @(posedge hclk) begin
    if (live0 && !gnt0) begin
      pend0_addr  <= m0_haddr;
      pend0_write <= m0_hwrite;
      pend0_size  <= m0_hsize;
    end
    if (live1 && !gnt1) begin
      pend1_addr  <= m1_haddr;
      pend1_write <= m1_hwrite;
      pend1_size  <= m1_hsize;
    end
    if (gnt0 || gnt1) begin
      hold_addr  <= s_haddr;
      hold_write <= s_hwrite;
      hold_size  <= s_hsize;
    end
  end

  // Master-side responses and write-data steering by data-phase owner
  always_comb begin
    m0_hrdata = s_hrdata;
    m1_hrdata = s_hrdata;
    m0_hready = 1'b1;
    m1_hready = 1'b1;
    m0_hresp  = 1'b0;
    m1_hresp  = 1'b0;
    s_hwdata  = '0;
    if (hresetn) begin
      if (pend0)                   m0_hready = 1'b0;
      else if (dp_owner == OWN_M0) m0_hready = s_hready;
      if (pend1)                   m1_hready = 1'b0;
      else if (dp_owner == OWN_M1) m1_hready = s_hready;
      if (dp_owner == OWN_M0) begin
        m0_hresp = s_hresp;
        s_hwdata = m0_hwdata;
      end else if (dp_owner == OWN_M1) begin
        m1_hresp = s_hresp;
        s_hwdata = m1_hwdata;
      end
    end
  end

endmodule

// File: tb/tb_vscale_hasti_sram_arbiter.sv
// Scoreboard bench for vscale_hasti_sram_arbiter: stimulus queues expected
// slave transfers and per-cycle control values; a monitor pops and compares.
module tb_vscale_hasti_sram_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS   = 2'b10;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [31:0] m0_haddr = '0, m1_haddr = '0;
  logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
  logic [2:0]  m0_hsize = 3'd2, m1_hsize = 3'd2;
  logic [1:0]  m0_htrans = IDLE, m1_htrans = IDLE;
  logic [31:0] m0_hwdata = '0, m1_hwdata = '0;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [1:0]  s_htrans;
  logic        s_hready = 1'b1;
  logic        s_hresp = 1'b0;

  logic [31:0] f_m0_hrdata, f_m1_hrdata, f_s_haddr, f_s_hwdata;
  logic        f_m0_hready, f_m1_hready, f_m0_hresp, f_m1_hresp, f_s_hwrite;
  logic [2:0]  f_s_hsize;
  logic [1:0]  f_s_htrans;

  always #5 hclk = ~hclk;

  vscale_hasti_sram_arbiter #(.FIXED_PRIO(0)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_htrans(s_htrans),
    .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  vscale_hasti_sram_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_htrans(m0_htrans),
    .m0_hwdata(m0_hwdata), .m0_hrdata(f_m0_hrdata), .m0_hready(f_m0_hready), .m0_hresp(f_m0_hresp),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_htrans(m1_htrans),
    .m1_hwdata(m1_hwdata), .m1_hrdata(f_m1_hrdata), .m1_hready(f_m1_hready), .m1_hresp(f_m1_hresp),
    .s_haddr(f_s_haddr), .s_hwrite(f_s_hwrite), .s_hsize(f_s_hsize), .s_htrans(f_s_htrans),
    .s_hwdata(f_s_hwdata), .s_hrdata(32'h0), .s_hready(s_hready), .s_hresp(1'b0)
  );

  // SRAM slave: write lands at the end of its data phase, reads are combinational
  logic [31:0] mem [0:255];
  logic        sl_vld = 1'b0, sl_write = 1'b0;
  logic [7:0]  sl_idx = '0;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
  always @(posedge hclk) begin
    if (!hresetn) sl_vld <= 1'b0;
    else if (s_hready) begin
      if (sl_vld && sl_write) mem[sl_idx] <= s_hwdata;
      sl_vld   <= (s_htrans == NS);
      sl_idx   <= s_haddr[9:2];
      sl_write <= s_hwrite;
    end
  end
  assign s_hrdata = sl_vld ? mem[sl_idx] : 32'h0;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic write; logic [31:0] data; int mst; } xfer_t;
  typedef struct { int tag; logic m0r; logic m1r; logic [1:0] trans; } ctl_t;
  xfer_t addr_q[$];
  ctl_t  ctl_q[$];
  int checks = 0;
  int passes = 0;
  logic fp_win = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got 0x%08h expected none (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations
  initial begin
    xfer_t fl;
    ctl_t  c;
    logic  fl_vld;
    fl_vld = 1'b0;
    forever begin
      @(negedge hclk);
      while (ctl_q.size() > 0 && ctl_q[0].tag < cyc) begin
        c = ctl_q.pop_front();
        flag_fail("ctl_missed", 32'(c.tag));
      end
      if (ctl_q.size() > 0 && ctl_q[0].tag == cyc) begin
        c = ctl_q.pop_front();
        check("m0_hready", 32'(m0_hready), 32'(c.m0r));
        check("m1_hready", 32'(m1_hready), 32'(c.m1r));
        check("s_htrans",  32'(s_htrans),  32'(c.trans));
      end
      if (!hresetn) fl_vld = 1'b0;
      else begin
        if (fl_vld && s_hready) begin
          if (fl.write)        check("s_hwdata",  s_hwdata,  fl.data);
          else if (fl.mst == 0) check("m0_hrdata", m0_hrdata, fl.data);
          else                 check("m1_hrdata", m1_hrdata, fl.data);
          fl_vld = 1'b0;
        end
        if (s_htrans == NS && s_hready) begin
          if (addr_q.size() == 0) flag_fail("unexpected_nonseq", s_haddr);
          else begin
            fl = addr_q.pop_front();
            check("s_haddr",  s_haddr,       fl.addr);
            check("s_hwrite", 32'(s_hwrite), 32'(fl.write));
            fl_vld = 1'b1;
          end
        end
      end
      if (fp_win) begin
        check("fp_nonseq",  32'(f_s_htrans),     32'(NS));
        check("fp_m0_only", 32'(f_s_haddr[11:8]), 32'h2);
      end
    end
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic expect_ctl(input logic m0r, input logic m1r, input logic [1:0] tr);
    ctl_q.push_back('{cyc, m0r, m1r, tr});
  endtask

  task automatic push_x(input logic [31:0] a, input logic w, input logic [31:0] d, input int mst);
    addr_q.push_back('{a, w, d, mst});
  endtask

  task automatic do_reset();
    hresetn   = 1'b0;
    m0_htrans = IDLE;
    m1_htrans = IDLE;
    s_hready  = 1'b1;
    expect_ctl(1'b1, 1'b1, IDLE);
    step();
    expect_ctl(1'b1, 1'b1, IDLE);
    step();
    hresetn = 1'b1;
  endtask

  initial begin
    logic [31:0] a0, a1, ad;
    logic acc0, acc1;
    step();

    // 1: lone m0 read passes through the same cycle
    do_reset();
    m0_htrans = NS; m0_haddr = 32'h100; m0_hwrite = 1'b0;
    push_x(32'h100, 1'b0, 32'hA500_0040, 0);
    expect_ctl(1'b1, 1'b1, NS);
    step(); m0_htrans = IDLE;
    expect_ctl(1'b1, 1'b1, IDLE);
    step(); step();

    // 2: simultaneous requests, m0 first, m1 replayed from its pending buffer
    do_reset();
    m0_htrans = NS; m0_haddr = 32'h10; m0_hwrite = 1'b0;
    m1_htrans = NS; m1_haddr = 32'h20; m1_hwrite = 1'b1; m1_hwdata = 32'h0;
    push_x(32'h10, 1'b0, 32'hA500_0004, 0);
    push_x(32'h20, 1'b1, 32'hDEAD_BEEF, 1);
    expect_ctl(1'b1, 1'b1, NS);
    step(); m0_htrans = IDLE; m1_htrans = IDLE; m1_hwdata = 32'hDEAD_BEEF;
    expect_ctl(1'b1, 1'b0, NS);
    step();
    expect_ctl(1'b1, 1'b1, IDLE);
    step(); step();

    // 3: continuous contention alternates; the fixed-priority instance only serves m0
    do_reset();
    a0 = 32'h200; a1 = 32'h300; m0_hwrite = 1'b0; m1_hwrite = 1'b0;
    fp_win = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0_htrans = NS; m0_haddr = a0;
      m1_htrans = NS; m1_haddr = a1;
      ad = ((i % 2) == 0) ? 32'h200 + 32'(4 * (i / 2)) : 32'h300 + 32'(4 * (i / 2));
      push_x(ad, 1'b0, 32'hA500_0000 + (ad >> 2), i % 2);
      @(negedge hclk);
      acc0 = m0_hready;
      acc1 = m1_hready;
      step();
      if (acc0) a0 = a0 + 32'd4;
      if (acc1) a1 = a1 + 32'd4;
    end
    fp_win = 1'b0;
    m0_htrans = IDLE; m1_htrans = IDLE;
    push_x(32'h210, 1'b0, 32'hA500_0084, 0);
    step(); step(); step();

    // 4: slave stall during m0 data phase; m1 captured and issued on release
    do_reset();
    m0_htrans = NS; m0_haddr = 32'h80; m0_hwrite = 1'b0;
    push_x(32'h80, 1'b0, 32'hA500_0020, 0);
    expect_ctl(1'b1, 1'b1, NS);
    step(); m0_htrans = IDLE; s_hready = 1'b0;
    m1_htrans = NS; m1_haddr = 32'h84; m1_hwrite = 1'b1;
    push_x(32'h84, 1'b1, 32'hCAFE_0084, 1);
    expect_ctl(1'b0, 1'b1, IDLE);
    step(); m1_htrans = IDLE; m1_hwdata = 32'hCAFE_0084;
    expect_ctl(1'b0, 1'b0, IDLE);
    step();
    expect_ctl(1'b0, 1'b0, IDLE);
    step(); s_hready = 1'b1;
    expect_ctl(1'b1, 1'b0, NS);
    step();
    expect_ctl(1'b1, 1'b1, IDLE);
    step(); step();

    // 5: reset with m0 in data phase and m1 pending drops both
    do_reset();
    m0_htrans = NS; m0_haddr = 32'h08; m0_hwrite = 1'b0;
    m1_htrans = NS; m1_haddr = 32'h0C; m1_hwrite = 1'b0;
    push_x(32'h08, 1'b0, 32'hA500_0002, 0);
    expect_ctl(1'b1, 1'b1, NS);
    step(); m0_htrans = IDLE; m1_htrans = IDLE; hresetn = 1'b0;
    expect_ctl(1'b1, 1'b1, IDLE);
    step(); hresetn = 1'b1;
    expect_ctl(1'b1, 1'b1, IDLE);
    step();
    expect_ctl(1'b1, 1'b1, IDLE);
    step(); step();

    // 6: m1 write followed by m0 read of the same word
    do_reset();
    m1_htrans = NS; m1_haddr = 32'h40; m1_hwrite = 1'b1;
    push_x(32'h40, 1'b1, 32'h1122_3344, 1);
    step(); m1_htrans = IDLE; m1_hwdata = 32'h1122_3344;
    m0_htrans = NS; m0_haddr = 32'h40; m0_hwrite = 1'b0;
    push_x(32'h40, 1'b0, 32'h1122_3344, 0);
    expect_ctl(1'b1, 1'b1, NS);
    step(); m0_htrans = IDLE;
    expect_ctl(1'b1, 1'b1, IDLE);
    step(); step(); step();

    check("addr_q_drained", 32'(addr_q.size()), 32'h0);
    check("ctl_q_drained",  32'(ctl_q.size()),  32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
